rr_arb_4_idx: RTL and testbench

RR_ARB_4_IDX -- requirements
Module: rr_arb_4_idx

---
 rtl/rr_arb_4_idx.sv | 118 +++++++++++
 tb/tb_rr_arb_4_idx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_4_idx.sv
// rr_arb_4_idx: four-requester round-robin arbiter with an encoded grant index.
//
// One grant is held at a time. It is released by done, by the grantee dropping
// its request, or by a hold-time limit of TIMEOUT cycles. Every release is followed
// by at least one idle cycle before the next grant. After a release, the
// requester after the released one gets first priority.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   req[3:0]   in   request lines, one per requester
//   done       in   current grantee releases its grant (ignored while idle)
//   idx[1:0]   out  encoded index of the current grantee (drives the 2x4 decoder select)
//   gnt_valid  out  idx holds an active grant
//   timeout    out  one-cycle pulse after a release forced only by the hold limit
module rr_arb_4_idx #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            timeout_q, timeout_d;

    logic [1:0] sel_idx;
    logic [1:0] cand;
    logic       found;
    logic       at_limit;
    logic       early_rel;

    // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first requester found wins.
    always_comb begin
        sel_idx = ptr_q;
        cand    = ptr_q;
        found   = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                sel_idx = cand;
                found   = 1'b1;
            end
        end
    end

    assign at_limit  = (cnt_q == CntMax);
    // Release requested by the grantee itself; it takes precedence over a limit hit.
    assign early_rel = done || !req[idx_q];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        gnt_valid_d = 1'b0;
        timeout_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d     = StGrant;
                    idx_d       = sel_idx;
                    cnt_d       = '0;
                    gnt_valid_d = 1'b1;
                end
            end
            StGrant: begin
                if (early_rel || at_limit) begin
                    state_d   = StIdle;
                    ptr_d     = idx_q + 2'd1;
                    timeout_d = !early_rel;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    gnt_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= 2'd0;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign idx       = idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb_4_idx.sv
module tb_rr_arb_4_idx;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] idx;
    logic       gnt_valid;
    logic       timeout;

    int checks;
    int failures;

    rr_arb_4_idx #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .idx       (idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are observed and inputs changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", idx); end
        checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt_valid); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    endtask

    // req=1010: grant 1, then 3, then 1 again after the pointer wraps.
    task automatic test_basic();
        do_reset();
        req = 4'b1010;
        tick();
        checks++; if (idx !== 2'd1 || gnt_valid !== 1'b1) begin failures++; $display("FAIL basic_g1 got idx=%0d gnt=%b exp idx=1 gnt=1", idx, gnt_valid); end
        tick();
        tick();
        tick();
        checks++; if (idx !== 2'd1 || gnt_valid !== 1'b1) begin failures++; $display("FAIL basic_hold got idx=%0d gnt=%b exp idx=1 gnt=1", idx, gnt_valid); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL basic_gap1 got gnt=%b to=%b exp 0 0", gnt_valid, timeout); end
        tick();
        checks++; if (idx !== 2'd3 || gnt_valid !== 1'b1) begin failures++; $display("FAIL basic_g3 got idx=%0d gnt=%b exp idx=3 gnt=1", idx, gnt_valid); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL basic_gap2 got gnt=%b exp 0", gnt_valid); end
        tick();
        checks++; if (idx !== 2'd1 || gnt_valid !== 1'b1) begin failures++; $display("FAIL basic_wrap got idx=%0d gnt=%b exp idx=1 gnt=1", idx, gnt_valid); end
        // Requests from others during a grant do not disturb it.
        req = 4'b1111;
        tick();
        checks++; if (idx !== 2'd1 || gnt_valid !== 1'b1) begin failures++; $display("FAIL basic_other_req got idx=%0d gnt=%b exp idx=1 gnt=1", idx, gnt_valid); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // req=1111: strict rotation 0,1,2,3,0 with one idle cycle between grants.
    task automatic test_back_to_back();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++; if (idx !== exp_seq[k] || gnt_valid !== 1'b1) begin failures++; $display("FAIL b2b_grant%0d got idx=%0d gnt=%b exp idx=%0d gnt=1", k, idx, gnt_valid, exp_seq[k]); end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap%0d got gnt=%b exp 0", k, gnt_valid); end
            tick();
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // req=0100 held: 16 grant cycles, timeout pulse in the gap, regrant to 2;
    // then done on the limit cycle gives a release with no pulse.
    task automatic test_timeout();
        do_reset();
        req = 4'b0100;
        tick();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            checks++; if (gnt_valid !== 1'b1 || idx !== 2'd2 || timeout !== 1'b0) begin failures++; $display("FAIL to_hold%0d got gnt=%b idx=%0d to=%b exp 1 2 0", k, gnt_valid, idx, timeout); end
        end
        tick();
        checks++; if (gnt_valid !== 1'b0 || timeout !== 1'b1) begin failures++; $display("FAIL to_pulse got gnt=%b to=%b exp gnt=0 to=1", gnt_valid, timeout); end
        tick();
        checks++; if (gnt_valid !== 1'b1 || idx !== 2'd2 || timeout !== 1'b0) begin failures++; $display("FAIL to_regrant got gnt=%b idx=%0d to=%b exp 1 2 0", gnt_valid, idx, timeout); end
        for (int k = 1; k < 16; k++) tick();
        checks++; if (gnt_valid !== 1'b1) begin failures++; $display("FAIL lim_hold got gnt=%b exp 1", gnt_valid); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL lim_done got gnt=%b to=%b exp 0 0", gnt_valid, timeout); end
        tick();
        checks++; if (gnt_valid !== 1'b1 || idx !== 2'd2 || timeout !== 1'b0) begin failures++; $display("FAIL lim_regrant got gnt=%b idx=%0d to=%b exp 1 2 0", gnt_valid, idx, timeout); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // Grantee drops its request mid-grant.
    task automatic test_req_drop();
        do_reset();
        req = 4'b0011;
        tick();
        checks++; if (idx !== 2'd0 || gnt_valid !== 1'b1) begin failures++; $display("FAIL drop_g0 got idx=%0d gnt=%b exp idx=0 gnt=1", idx, gnt_valid); end
        tick();
        req = 4'b0010;
        tick();
        checks++; if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL drop_rel got gnt=%b to=%b exp 0 0", gnt_valid, timeout); end
        tick();
        checks++; if (idx !== 2'd1 || gnt_valid !== 1'b1) begin failures++; $display("FAIL drop_g1 got idx=%0d gnt=%b exp idx=1 gnt=1", idx, gnt_valid); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // Reset during a grant, regrant after; then idle hold with done ignored.
    task automatic test_rst_grant();
        do_reset();
        req = 4'b1000;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0100;
        tick();
        checks++; if (idx !== 2'd2 || gnt_valid !== 1'b1) begin failures++; $display("FAIL rstg_pre got idx=%0d gnt=%b exp idx=2 gnt=1", idx, gnt_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (idx !== 2'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL rstg_rst got idx=%0d gnt=%b to=%b exp 0 0 0", idx, gnt_valid, timeout); end
        tick();
        checks++; if (idx !== 2'd2 || gnt_valid !== 1'b1) begin failures++; $display("FAIL rstg_regrant got idx=%0d gnt=%b exp idx=2 gnt=1", idx, gnt_valid); end
        done = 1'b1;
        tick();
        req = 4'b0000;
        tick();
        tick();
        done = 1'b0;
        checks++; if (idx !== 2'd2 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL idle_hold got idx=%0d gnt=%b to=%b exp 2 0 0", idx, gnt_valid, timeout); end
        // Pointer is now 3: req=0011 must pick 0 before 1.
        req = 4'b0011;
        tick();
        checks++; if (idx !== 2'd0 || gnt_valid !== 1'b1) begin failures++; $display("FAIL idle_ptr got idx=%0d gnt=%b exp idx=0 gnt=1", idx, gnt_valid); end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        done     = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_req_drop();
        test_rst_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
